// File: rtl/net_cmd_unit.sv
// Network command front-end: buffers packets addressed to this core and
// dispatches imem, rf, PC and barrier-mask writes strictly in arrival order.
module net_cmd_unit #(
    parameter int net_ID_p        = 1,
    parameter int id_width_p      = 10,
    parameter int addr_width_p    = 10,
    parameter int data_width_p    = 32,
    parameter int instr_width_p   = 16,
    parameter int rf_addr_width_p = 10,
    parameter int mask_width_p    = 3,
    parameter int fifo_depth_p    = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       net_v_i,
    input  logic [id_width_p-1:0]      net_id_i,
    input  logic [2:0]                 net_op_i,
    input  logic [addr_width_p-1:0]    net_addr_i,
    input  logic [data_width_p-1:0]    net_data_i,
    output logic                       net_ready_o,
    input  logic [1:0]                 core_state_i,
    output logic                       imem_w_v_o,
    input  logic                       imem_w_ready_i,
    output logic [addr_width_p-1:0]    imem_w_addr_o,
    output logic [instr_width_p-1:0]   imem_w_data_o,
    output logic                       rf_w_v_o,
    input  logic                       rf_w_ready_i,
    output logic [rf_addr_width_p-1:0] rf_w_addr_o,
    output logic [data_width_p-1:0]    rf_w_data_o,
    output logic                       pc_w_v_o,
    output logic [addr_width_p-1:0]    pc_w_addr_o,
    input  logic                       bar_v_i,
    input  logic [mask_width_p-1:0]    bar_val_i,
    output logic [mask_width_p-1:0]    barrier_o,
    output logic [mask_width_p-1:0]    barrier_mask_o,
    output logic                       exception_o,
    output logic [7:0]                 drop_cnt_o
);

    localparam int PW = $clog2(fifo_depth_p);

    localparam logic [2:0] OP_INSTR = 3'd1;
    localparam logic [2:0] OP_REG   = 3'd2;
    localparam logic [2:0] OP_PC    = 3'd3;
    localparam logic [2:0] OP_BAR   = 3'd4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ERR  = 2'd2;

    logic [2:0]              r_op_mem   [fifo_depth_p];
    logic [addr_width_p-1:0] r_addr_mem [fifo_depth_p];
    logic [data_width_p-1:0] r_data_mem [fifo_depth_p];

    // One extra pointer bit distinguishes full from empty.
    logic [PW:0] r_wr_ptr;
    logic [PW:0] r_rd_ptr;

    logic [mask_width_p-1:0] r_barrier_mask;
    logic [mask_width_p-1:0] r_barrier_val;
    logic                    r_exception;
    logic [7:0]              r_drop_cnt;

    logic                    w_full;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_drop;
    logic                    w_pc_load;
    logic                    w_bar_load;
    logic                    w_pc_reject;
    logic [2:0]              w_head_op;
    logic [addr_width_p-1:0] w_head_addr;
    logic [data_width_p-1:0] w_head_data;
    logic                    w_is_instr;
    logic                    w_is_reg;
    logic                    w_is_pc;
    logic                    w_is_bar;
    logic                    w_is_other;
    logic                    w_st_idle;
    logic                    w_st_err;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                     (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);

    assign net_ready_o = ~w_full;
    assign w_push      = net_v_i && (net_id_i == id_width_p'(net_ID_p)) && !w_full;

    assign w_head_op   = r_op_mem[r_rd_ptr[PW-1:0]];
    assign w_head_addr = r_addr_mem[r_rd_ptr[PW-1:0]];
    assign w_head_data = r_data_mem[r_rd_ptr[PW-1:0]];

    assign w_is_instr = !w_empty && (w_head_op == OP_INSTR);
    assign w_is_reg   = !w_empty && (w_head_op == OP_REG);
    assign w_is_pc    = !w_empty && (w_head_op == OP_PC);
    assign w_is_bar   = !w_empty && (w_head_op == OP_BAR);
    assign w_is_other = !w_empty && !(w_is_instr || w_is_reg || w_is_pc || w_is_bar);

    assign w_st_idle = (core_state_i == ST_IDLE);
    assign w_st_err  = (core_state_i == ST_ERR);

    assign w_pc_load   = w_is_pc && w_st_idle;
    assign w_pc_reject = w_is_pc && !w_st_idle;
    assign w_bar_load  = w_is_bar && !w_st_err;
    assign w_drop      = w_pc_reject || (w_is_bar && w_st_err) || w_is_other;

    // Only imem/rf writes can stall; every other op retires in one cycle.
    assign w_pop = (w_is_instr && imem_w_ready_i) ||
                   (w_is_reg && rf_w_ready_i) ||
                   w_is_pc || w_is_bar || w_is_other;

    assign imem_w_v_o    = w_is_instr;
    assign imem_w_addr_o = w_head_addr;
    assign imem_w_data_o = w_head_data[instr_width_p-1:0];

    assign rf_w_v_o    = w_is_reg;
    assign rf_w_addr_o = w_head_addr[rf_addr_width_p-1:0];
    assign rf_w_data_o = w_head_data;

    assign pc_w_v_o    = w_pc_load;
    assign pc_w_addr_o = w_head_addr;

    assign barrier_o      = r_barrier_mask & r_barrier_val;
    assign barrier_mask_o = r_barrier_mask;
    assign exception_o    = r_exception;
    assign drop_cnt_o     = r_drop_cnt;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_op_mem[r_wr_ptr[PW-1:0]]   <= net_op_i;
            r_addr_mem[r_wr_ptr[PW-1:0]] <= net_addr_i;
            r_data_mem[r_wr_ptr[PW-1:0]] <= net_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_barrier_mask <= '0;
            r_barrier_val  <= '0;
            r_exception    <= 1'b0;
            r_drop_cnt     <= '0;
        end else begin
            if (w_bar_load) r_barrier_mask <= w_head_data[mask_width_p-1:0];
            // A PC load from the network overrides a same-cycle core BAR commit.
            if (w_pc_load)    r_barrier_val <= w_head_data[mask_width_p-1:0];
            else if (bar_v_i) r_barrier_val <= bar_val_i;
            if (w_pc_reject || w_st_err) r_exception <= 1'b1;
            if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_net_cmd_unit.sv
// Directed bench for net_cmd_unit: ordering, back-pressure, PC/BAR handling,
// drops, saturation and mid-stream reset, checked against hand-derived values.
module tb_net_cmd_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        net_v_i;
    logic [9:0]  net_id_i;
    logic [2:0]  net_op_i;
    logic [9:0]  net_addr_i;
    logic [31:0] net_data_i;
    logic        net_ready_o;
    logic [1:0]  core_state_i;
    logic        imem_w_v_o;
    logic        imem_w_ready_i;
    logic [9:0]  imem_w_addr_o;
    logic [15:0] imem_w_data_o;
    logic        rf_w_v_o;
    logic        rf_w_ready_i;
    logic [9:0]  rf_w_addr_o;
    logic [31:0] rf_w_data_o;
    logic        pc_w_v_o;
    logic [9:0]  pc_w_addr_o;
    logic        bar_v_i;
    logic [2:0]  bar_val_i;
    logic [2:0]  barrier_o;
    logic [2:0]  barrier_mask_o;
    logic        exception_o;
    logic [7:0]  drop_cnt_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    net_cmd_unit dut (
        .clk            (clk),
        .reset          (reset),
        .net_v_i        (net_v_i),
        .net_id_i       (net_id_i),
        .net_op_i       (net_op_i),
        .net_addr_i     (net_addr_i),
        .net_data_i     (net_data_i),
        .net_ready_o    (net_ready_o),
        .core_state_i   (core_state_i),
        .imem_w_v_o     (imem_w_v_o),
        .imem_w_ready_i (imem_w_ready_i),
        .imem_w_addr_o  (imem_w_addr_o),
        .imem_w_data_o  (imem_w_data_o),
        .rf_w_v_o       (rf_w_v_o),
        .rf_w_ready_i   (rf_w_ready_i),
        .rf_w_addr_o    (rf_w_addr_o),
        .rf_w_data_o    (rf_w_data_o),
        .pc_w_v_o       (pc_w_v_o),
        .pc_w_addr_o    (pc_w_addr_o),
        .bar_v_i        (bar_v_i),
        .bar_val_i      (bar_val_i),
        .barrier_o      (barrier_o),
        .barrier_mask_o (barrier_mask_o),
        .exception_o    (exception_o),
        .drop_cnt_o     (drop_cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one packet for one clock edge; afterwards inputs are idle and
    // the packet (if accepted) may already be at the FIFO head.
    task automatic push(input logic [9:0] id, input logic [2:0] op,
                        input logic [9:0] addr, input logic [31:0] data);
        net_v_i    = 1'b1;
        net_id_i   = id;
        net_op_i   = op;
        net_addr_i = addr;
        net_data_i = data;
        $display("push id=%0d op=%0d addr=%0h data=%0h ready=%0b", id, op, addr, data, net_ready_o);
        step();
        net_v_i = 1'b0;
    endtask

    initial begin
        reset = 1'b1; net_v_i = 1'b0; net_id_i = '0; net_op_i = '0;
        net_addr_i = '0; net_data_i = '0; core_state_i = 2'd0;
        imem_w_ready_i = 1'b1; rf_w_ready_i = 1'b1; bar_v_i = 1'b0; bar_val_i = '0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_ready", net_ready_o, 1);
        check("rst_imem_v", imem_w_v_o, 0);
        check("rst_rf_v", rf_w_v_o, 0);
        check("rst_pc_v", pc_w_v_o, 0);
        check("rst_mask", barrier_mask_o, 0);
        check("rst_barrier", barrier_o, 0);
        check("rst_exc", exception_o, 0);
        check("rst_drop", drop_cnt_o, 0);

        // Three INSTR packets streamed with imem always ready.
        push(10'd1, 3'd1, 10'd0, 32'h0000_A001);
        check("i0_v", imem_w_v_o, 1);
        check("i0_addr", imem_w_addr_o, 0);
        check("i0_data", imem_w_data_o, 16'hA001);
        push(10'd1, 3'd1, 10'd1, 32'h0000_A002);
        check("i1_addr", imem_w_addr_o, 1);
        check("i1_data", imem_w_data_o, 16'hA002);
        check("i1_ready", net_ready_o, 1);
        push(10'd1, 3'd1, 10'd2, 32'h0000_A003);
        check("i2_addr", imem_w_addr_o, 2);
        check("i2_data", imem_w_data_o, 16'hA003);
        step();
        check("i_done_v", imem_w_v_o, 0);

        // REG stalled for four cycles, INSTR queued behind it.
        rf_w_ready_i = 1'b0;
        push(10'd1, 3'd2, 10'd5, 32'hDEAD_BEEF);
        check("reg_c1_v", rf_w_v_o, 1);
        check("reg_c1_addr", rf_w_addr_o, 5);
        check("reg_c1_data", rf_w_data_o, 32'hDEAD_BEEF);
        push(10'd1, 3'd1, 10'd7, 32'h0000_1234);
        check("reg_c2_v", rf_w_v_o, 1);
        check("reg_c2_noimem", imem_w_v_o, 0);
        step();
        check("reg_c3_addr", rf_w_addr_o, 5);
        step();
        check("reg_c4_data", rf_w_data_o, 32'hDEAD_BEEF);
        step();
        rf_w_ready_i = 1'b1;
        check("reg_c5_v", rf_w_v_o, 1);
        step();
        check("reg_after_rf_v", rf_w_v_o, 0);
        check("reg_next_imem_v", imem_w_v_o, 1);
        check("reg_next_addr", imem_w_addr_o, 7);
        step();
        check("reg_next_done", imem_w_v_o, 0);

        // Fill the FIFO with imem stalled; fifth packet waits for a pop.
        imem_w_ready_i = 1'b0;
        push(10'd1, 3'd1, 10'd10, 32'h0000_B000);
        push(10'd1, 3'd1, 10'd11, 32'h0000_B001);
        push(10'd1, 3'd1, 10'd12, 32'h0000_B002);
        check("fill3_ready", net_ready_o, 1);
        push(10'd1, 3'd1, 10'd13, 32'h0000_B003);
        check("full_ready", net_ready_o, 0);
        check("full_head", imem_w_addr_o, 10);
        net_v_i = 1'b1; net_id_i = 10'd1; net_op_i = 3'd1;
        net_addr_i = 10'd14; net_data_i = 32'h0000_B004;
        imem_w_ready_i = 1'b1;
        check("full_hold_ready", net_ready_o, 0);
        step();
        check("pop1_ready", net_ready_o, 1);
        check("pop1_head", imem_w_addr_o, 11);
        step();
        net_v_i = 1'b0;
        check("ord_12", imem_w_addr_o, 12);
        step();
        check("ord_13", imem_w_addr_o, 13);
        step();
        check("ord_14", imem_w_addr_o, 14);
        check("ord_14_data", imem_w_data_o, 16'hB004);
        step();
        check("ord_empty", imem_w_v_o, 0);

        // PC in IDLE loads, PC in RUN raises the exception and drops.
        push(10'd1, 3'd3, 10'h020, 32'd5);
        check("pc_idle_v", pc_w_v_o, 1);
        check("pc_idle_addr", pc_w_addr_o, 10'h020);
        step();
        check("pc_idle_pulse_end", pc_w_v_o, 0);
        core_state_i = 2'd1;
        push(10'd1, 3'd3, 10'h020, 32'd5);
        check("pc_run_nopulse", pc_w_v_o, 0);
        check("pc_run_exc_pre", exception_o, 0);
        step();
        check("pc_run_exc", exception_o, 1);
        check("pc_run_drop", drop_cnt_o, 1);

        // BAR sets mask; barrier value 101 from the PC load shows through.
        push(10'd1, 3'd4, 10'd0, 32'd3);
        step();
        check("bar_mask", barrier_mask_o, 3'b011);
        check("bar_barrier", barrier_o, 3'b001);
        bar_v_i = 1'b1; bar_val_i = 3'b111;
        step();
        bar_v_i = 1'b0;
        check("barv_barrier", barrier_o, 3'b011);
        core_state_i = 2'd2;
        push(10'd1, 3'd4, 10'd0, 32'd6);
        step();
        check("bar_err_mask", barrier_mask_o, 3'b011);
        check("bar_err_drop", drop_cnt_o, 2);
        core_state_i = 2'd0;

        // PC load and core BAR commit in the same cycle: PC wins.
        push(10'd1, 3'd3, 10'h030, 32'd4);
        bar_v_i = 1'b1; bar_val_i = 3'b111;
        check("pcbar_v", pc_w_v_o, 1);
        step();
        bar_v_i = 1'b0;
        check("pcbar_barrier", barrier_o, 3'b000);

        // Foreign ID ignored; illegal op dropped.
        push(10'd2, 3'd1, 10'h055, 32'h0000_C000);
        check("id2_imem_v", imem_w_v_o, 0);
        check("id2_drop", drop_cnt_o, 2);
        push(10'd1, 3'd6, 10'd0, 32'd0);
        step();
        check("op6_drop", drop_cnt_o, 3);
        check("op6_imem_v", imem_w_v_o, 0);

        // Reset with three packets queued discards them.
        imem_w_ready_i = 1'b0;
        push(10'd1, 3'd1, 10'd1, 32'h0000_D001);
        push(10'd1, 3'd1, 10'd2, 32'h0000_D002);
        push(10'd1, 3'd1, 10'd3, 32'h0000_D003);
        check("prerst_v", imem_w_v_o, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        imem_w_ready_i = 1'b1;
        check("mrst_imem_v", imem_w_v_o, 0);
        check("mrst_ready", net_ready_o, 1);
        check("mrst_drop", drop_cnt_o, 0);
        check("mrst_exc", exception_o, 0);
        check("mrst_mask", barrier_mask_o, 0);
        step();
        check("mrst_imem_v2", imem_w_v_o, 0);

        // 260 NULL packets: counter must stop at 255.
        for (int i = 0; i < 260; i++) push(10'd1, 3'd0, 10'(i), 32'(i));
        step();
        step();
        check("drop_sat", drop_cnt_o, 8'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/net_cmd_unit.md
Name: net_cmd_unit

Overview:
- Parametrised network command front-end for one core.
- Replaces the core's inline network decode with a buffered unit:
  - accepts addressed packets into a FIFO;
  - dispatches imem, rf, PC and barrier-mask writes over ready/valid channels;
  - owns the barrier mask, barrier value and sticky exception.
- Sits between the network ring and the core datapath.

Parameters:
net_ID_p, 1, ID this unit answers to
id_width_p, 10, packet ID width
addr_width_p, 10, net_addr width (imem address width)
data_width_p, 32, net_data width
instr_width_p, 16, imem write data width (low bits of net_data)
rf_addr_width_p, 10, rf write address width (low bits of net_addr)
mask_width_p, 3, barrier mask/value width
fifo_depth_p, 4, packet FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
net_v_i  in  1  packet valid
net_id_i  in  id_width_p  packet ID
net_op_i  in  3  0 NULL, 1 INSTR, 2 REG, 3 PC, 4 BAR, 5-7 illegal
net_addr_i  in  addr_width_p  packet address
net_data_i  in  data_width_p  packet data
net_ready_o  out  1  FIFO can accept
core_state_i  in  2  0 IDLE, 1 RUN, 2 ERR
imem_w_v_o / imem_w_ready_i  out / in  1  imem write handshake
imem_w_addr_o  out  addr_width_p  imem write address
imem_w_data_o  out  instr_width_p  imem write data
rf_w_v_o / rf_w_ready_i  out / in  1  rf write handshake
rf_w_addr_o  out  rf_addr_width_p  rf write address
rf_w_data_o  out  data_width_p  rf write data
pc_w_v_o  out  1  one-cycle PC load pulse
pc_w_addr_o  out  addr_width_p  new PC
bar_v_i  in  1  core commits BAR instruction
bar_val_i  in  mask_width_p  BAR result
barrier_o  out  mask_width_p  barrier_mask_r & barrier_val_r
barrier_mask_o  out  mask_width_p  current mask
exception_o  out  1  sticky exception
drop_cnt_o  out  8  dropped-packet count, saturating

Behaviour:
Reset:
- FIFO empty; net_ready_o=1 in the cycle after reset deasserts.
- All *_v_o=0; mask, barrier value, exception and drop_cnt = 0.
- Reset mid-dispatch discards all queued packets.

Accept:
- Enqueue when net_v_i & net_id_i==net_ID_p & net_ready_o.
- net_ready_o = ~full; no same-cycle bypass when full.
- Non-matching IDs are ignored regardless of FIFO state.

Latency:
- A packet enqueued in cycle t is at the head in cycle t+1 at the earliest.
- Outputs are driven combinationally from the head entry.

Dispatch (head only, at most one pop per cycle, strict order):
- INSTR: imem_w_v_o=1 with addr/data; pop when imem_w_ready_i.
- REG: rf_w_v_o=1; pop when rf_w_ready_i.
- While not ready, hold the head and its outputs stable; no reordering.
- PC with core_state_i==IDLE: pc_w_v_o=1 for exactly one cycle, pop, barrier_val_r<=net_data[mask_width_p-1:0].
- PC in RUN/ERR: pop, no pulse, exception_o<=1, drop_cnt++.
- BAR with core_state_i!=ERR: barrier_mask_r<=net_data low bits, pop.
- BAR with core_state_i==ERR: pop, drop_cnt++, mask unchanged.
- NULL or illegal op: pop, drop_cnt++.

Exception and barrier:
- exception_o also sets whenever core_state_i==ERR.
- exception_o clears only on reset.
- bar_v_i: barrier_val_r<=bar_val_i. A same-cycle PC-IDLE dispatch wins.

Counters:
- drop_cnt_o saturates at 255.

Empty FIFO:
- All *_v_o=0.
- Push and pop in the same cycle are legal when not full.
- FIFO pointers wrap modulo fifo_depth_p.

Test Plan:
- Reset, then 3 INSTR (addr 0,1,2, data 16'hA001..A003) to ID 1, imem_w_ready_i=1 -> imem writes on cycles t+1..t+3 in order; net_ready_o stays 1.
- REG addr 5 data 32'hDEAD_BEEF with rf_w_ready_i low 4 cycles, then high -> rf_w_v_o held 4 cycles with stable addr/data; pop on cycle 5; next packet follows.
- Push 5 packets with downstream ready=0, depth 4 -> net_ready_o=0 after 4th; 5th not taken until one pop; all 5 emerge in order.
- PC addr 10'h020 data 3'b101, state IDLE -> pc_w_v_o one-cycle pulse, pc_w_addr_o=20h; barrier_val=101. Same packet in RUN -> no pulse, exception_o=1, drop_cnt_o=1.
- BAR data 3'b011, then bar_v_i with 3'b111 -> barrier_o=011. BAR in ERR -> mask unchanged, drop_cnt increments.
- Packet ID 2 -> ignored. op=6 -> dropped. Reset asserted with 3 queued -> FIFO empty, no writes issued, counters 0.
